// File: rtl/sound_pkg.sv
// Shared types and constants for the sound sequencer.
//   state_t    - sequencer FSM states
//   melody_t   - which melody is selected or playing
//   F_*        - tone frequencies in Hz, as driven to the tone generator
//   melody_last(), melody_note() - per-melody length and note tables
package sound_pkg;

    localparam int CNT_W  = 26;
    localparam int FREQ_W = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MEL_NONE,
        MEL_LOSE,
        MEL_WIN,
        MEL_GATE
    } melody_t;

    localparam logic [FREQ_W-1:0] F_500 = 10'd500;
    localparam logic [FREQ_W-1:0] F_650 = 10'd650;
    localparam logic [FREQ_W-1:0] F_700 = 10'd700;
    localparam logic [FREQ_W-1:0] F_800 = 10'd800;
    localparam logic [FREQ_W-1:0] F_950 = 10'd950;

    // Index of the final note of each melody.
    function automatic logic [1:0] melody_last(input melody_t m);
        case (m)
            MEL_LOSE: return 2'd2;
            MEL_WIN:  return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

    function automatic logic [FREQ_W-1:0] melody_note(input melody_t m, input logic [1:0] idx);
        case (m)
            MEL_LOSE: begin
                case (idx)
                    2'd0:    return F_950;
                    2'd1:    return F_700;
                    default: return F_500;
                endcase
            end
            MEL_WIN: begin
                case (idx)
                    2'd0:    return F_500;
                    2'd1:    return F_650;
                    2'd2:    return F_800;
                    default: return F_950;
                endcase
            end
            MEL_GATE: return F_800;
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/sound_sequencer_tick_counter.sv
// tick_counter: loadable down-counter that stops at zero.
//   clk, resetN - clock, asynchronous active-low reset
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value to load
//   expired     - high while the count is zero
module tick_counter
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             resetN,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: asynchronous reset belongs in the sensitivity list; sequential
    // state is always written with non-blocking assignments.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: plays short fixed melodies on request.
//   clk, resetN      - 50 MHz clock, asynchronous active-low reset
//   lose_req         - level-lost melody request (950/700/500 Hz)
//   win_req          - level-won melody request (500/650/800/950 Hz)
//   gate_req         - frog-took-gate melody request (800 Hz)
//   sound_freq_out   - tone frequency in Hz, 0 when idle
//   enable_sound     - tone generator enable, high while a note sounds
//   busy             - high whenever not idle
//   done             - one-cycle pulse when a melody ends or is preempted
// Every output is decoded from registers only.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int unsigned NOTE_TICKS = 12500000,
    parameter int unsigned GAP_TICKS  = 2500000
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              lose_req,
    input  logic              win_req,
    input  logic              gate_req,
    output logic [FREQ_W-1:0] sound_freq_out,
    output logic              enable_sound,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] NOTE_LOAD = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);

    state_t     state, state_n;
    melody_t    cur_mel, mel_n, sel;
    logic [1:0] note_idx, idx_n;
    logic       pend_lose, pend_win, pend_gate;
    logic       clr_lose, clr_win, clr_gate;
    logic       preempted, preempt_n;
    logic       cnt_load, cnt_expired;
    logic [CNT_W-1:0] cnt_val;
    logic       abort_gate, can_start;

    tick_counter u_tick (
        .clk        (clk),
        .resetN     (resetN),
        .load       (cnt_load),
        .load_value (cnt_val),
        .expired    (cnt_expired)
    );

    // Highest-priority melody among pending flags and live requests.
    always_comb begin
        if (pend_lose || lose_req)      sel = MEL_LOSE;
        else if (pend_win || win_req)   sel = MEL_WIN;
        else if (pend_gate || gate_req) sel = MEL_GATE;
        else                            sel = MEL_NONE;
    end

    // Only GATE can be interrupted, and only by LOSE or WIN.
    assign abort_gate = (cur_mel == MEL_GATE) && (lose_req || win_req);
    // A preempted GATE hands over straight from DONE, skipping IDLE.
    assign can_start  = (state == S_IDLE) || ((state == S_DONE) && preempted);

    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n   = state;
        mel_n     = cur_mel;
        idx_n     = note_idx;
        preempt_n = preempted;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        clr_lose  = 1'b0;
        clr_win   = 1'b0;
        clr_gate  = 1'b0;

        case (state)
            S_IDLE: ;
            S_PLAY: begin
                if (abort_gate) begin
                    state_n   = S_DONE;
                    clr_gate  = 1'b1;
                    preempt_n = 1'b1;
                end else if (cnt_expired) begin
                    if (note_idx == melody_last(cur_mel)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n  = S_GAP;
                        cnt_load = 1'b1;
                        cnt_val  = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (abort_gate) begin
                    state_n   = S_DONE;
                    clr_gate  = 1'b1;
                    preempt_n = 1'b1;
                end else if (cnt_expired) begin
                    state_n  = S_PLAY;
                    idx_n    = note_idx + 2'd1;
                    cnt_load = 1'b1;
                    cnt_val  = NOTE_LOAD;
                end
            end
            S_DONE: begin
                state_n   = S_IDLE;
                mel_n     = MEL_NONE;
                preempt_n = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase

        if (can_start && (sel != MEL_NONE)) begin
            state_n   = S_PLAY;
            mel_n     = sel;
            idx_n     = 2'd0;
            preempt_n = 1'b0;
            cnt_load  = 1'b1;
            cnt_val   = NOTE_LOAD;
            case (sel)
                MEL_LOSE: clr_lose = 1'b1;
                MEL_WIN:  clr_win  = 1'b1;
                default:  clr_gate = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= S_IDLE;
            cur_mel   <= MEL_NONE;
            note_idx  <= 2'd0;
            preempted <= 1'b0;
            pend_lose <= 1'b0;
            pend_win  <= 1'b0;
            pend_gate <= 1'b0;
        end else begin
            state     <= state_n;
            cur_mel   <= mel_n;
            note_idx  <= idx_n;
            preempted <= preempt_n;
            // Clearing on the selection edge wins over a request still held.
            pend_lose <= clr_lose ? 1'b0 : (pend_lose | lose_req);
            pend_win  <= clr_win  ? 1'b0 : (pend_win  | win_req);
            pend_gate <= clr_gate ? 1'b0 : (pend_gate | gate_req);
        end
    end

    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign enable_sound   = (state == S_PLAY);
    assign sound_freq_out = ((state == S_PLAY) || (state == S_GAP))
                            ? melody_note(cur_mel, note_idx) : '0;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with NOTE_TICKS=4, GAP_TICKS=2.
// Cycle c of a melody is the clock period following the edge that
// started it (c=1 is the first note cycle).
module tb_sound_sequencer;

    localparam int NT  = 4;
    localparam int GT  = 2;
    localparam int PER = NT + GT;

    logic       clk = 1'b0;
    logic       resetN;
    logic       lose_req, win_req, gate_req;
    logic [9:0] sound_freq_out;
    logic       enable_sound, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    int lose_f [4] = '{950, 700, 500, 0};
    int win_f  [4] = '{500, 650, 800, 950};

    always #5 clk = ~clk;

    sound_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .lose_req       (lose_req),
        .win_req        (win_req),
        .gate_req       (gate_req),
        .sound_freq_out (sound_freq_out),
        .enable_sound   (enable_sound),
        .busy           (busy),
        .done           (done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected enable for cycle c of a melody with len notes.
    function automatic logic mel_en(input int c, input int len);
        return (((c - 1) / PER) < len) && (((c - 1) % PER) < NT);
    endfunction

    task automatic test_reset;
        resetN = 1'b0; lose_req = 1'b0; win_req = 1'b0; gate_req = 1'b0;
        step();
        lose_req = 1'b1;  // ignored while reset is held
        step();
        n_checks++;
        if ({sound_freq_out, enable_sound, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got freq=%0d en=%b busy=%b done=%b want all 0",
                     sound_freq_out, enable_sound, busy, done);
        end
        lose_req = 1'b0;
        step();
        resetN = 1'b1;
    endtask

    // Request raised right after reset release: first edge must be honoured.
    task automatic test_lose_single;
        logic [2:0] got, want;
        lose_req = 1'b1;
        step();
        lose_req = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) step();
            got  = {enable_sound, busy, done};
            want = {mel_en(c, 3), 1'b1, (c == 17)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL lose_single c%0d en/busy/done: got %b want %b", c, got, want);
            end
            if (c < 17) begin
                n_checks++;
                if (sound_freq_out !== 10'(lose_f[(c - 1) / PER])) begin
                    n_fail++;
                    $display("FAIL lose_single c%0d freq: got %0d want %0d",
                             c, sound_freq_out, lose_f[(c - 1) / PER]);
                end
            end
        end
        step();
        n_checks++;
        if ({sound_freq_out, enable_sound, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL lose_single idle: got freq=%0d en=%b busy=%b done=%b want all 0",
                     sound_freq_out, enable_sound, busy, done);
        end
    endtask

    // LOSE and WIN together: LOSE first, one idle cycle, then WIN.
    task automatic test_lose_win_same_cycle;
        logic [2:0] got, want;
        int len, f;
        lose_req = 1'b1; win_req = 1'b1;
        step();
        lose_req = 1'b0; win_req = 1'b0;
        for (int m = 0; m < 2; m++) begin
            len = (m == 0) ? 3 : 4;
            for (int c = 1; c <= PER * len - 1; c++) begin
                if (c > 1) step();
                f    = (m == 0) ? lose_f[(c - 1) / PER] : win_f[(c - 1) / PER];
                got  = {enable_sound, busy, done};
                want = {mel_en(c, len), 1'b1, (c == PER * len - 1)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL lose_win m%0d c%0d en/busy/done: got %b want %b", m, c, got, want);
                end
                if (c < PER * len - 1) begin
                    n_checks++;
                    if (sound_freq_out !== 10'(f)) begin
                        n_fail++;
                        $display("FAIL lose_win m%0d c%0d freq: got %0d want %0d", m, c, sound_freq_out, f);
                    end
                end
            end
            step();
            n_checks++;
            if ({enable_sound, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL lose_win m%0d idle: got en/busy/done %b want 000",
                         m, {enable_sound, busy, done});
            end
            if (m == 0) step();  // WIN cycle 1 follows the idle cycle
        end
    endtask

    // GATE preempted by WIN two cycles in; GATE must not resume.
    task automatic test_gate_preempt;
        logic [2:0] got, want;
        gate_req = 1'b1;
        step();
        gate_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            if (c > 1) step();
            n_checks++;
            if ({enable_sound, sound_freq_out} !== {1'b1, 10'd800}) begin
                n_fail++;
                $display("FAIL gate_preempt c%0d: got en=%b freq=%0d want en=1 freq=800",
                         c, enable_sound, sound_freq_out);
            end
        end
        win_req = 1'b1;
        step();
        win_req = 1'b0;
        n_checks++;
        if ({enable_sound, busy, done} !== 3'b011) begin
            n_fail++;
            $display("FAIL gate_preempt done: got en/busy/done %b want 011", {enable_sound, busy, done});
        end
        for (int c = 1; c <= 23; c++) begin
            step();
            got  = {enable_sound, busy, done};
            want = {mel_en(c, 4), 1'b1, (c == 23)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL gate_preempt win c%0d en/busy/done: got %b want %b", c, got, want);
            end
            if (c < 23) begin
                n_checks++;
                if (sound_freq_out !== 10'(win_f[(c - 1) / PER])) begin
                    n_fail++;
                    $display("FAIL gate_preempt win c%0d freq: got %0d want %0d",
                             c, sound_freq_out, win_f[(c - 1) / PER]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({sound_freq_out, enable_sound, busy} !== 12'd0) begin
                n_fail++;
                $display("FAIL gate_preempt no_resume k%0d: got freq=%0d en=%b busy=%b want all 0",
                         k, sound_freq_out, enable_sound, busy);
            end
        end
    endtask

    // LOSE during WIN's second note: WIN completes, LOSE follows.
    task automatic test_win_then_lose;
        logic [2:0] got, want;
        int len, f;
        win_req = 1'b1;
        step();
        win_req = 1'b0;
        for (int m = 0; m < 2; m++) begin
            len = (m == 0) ? 4 : 3;
            for (int c = 1; c <= PER * len - 1; c++) begin
                if (c > 1) step();
                f    = (m == 0) ? win_f[(c - 1) / PER] : lose_f[(c - 1) / PER];
                got  = {enable_sound, busy, done};
                want = {mel_en(c, len), 1'b1, (c == PER * len - 1)};
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL win_lose m%0d c%0d en/busy/done: got %b want %b", m, c, got, want);
                end
                if (c < PER * len - 1) begin
                    n_checks++;
                    if (sound_freq_out !== 10'(f)) begin
                        n_fail++;
                        $display("FAIL win_lose m%0d c%0d freq: got %0d want %0d", m, c, sound_freq_out, f);
                    end
                end
                if (m == 0 && c == 7) lose_req = 1'b1;
                if (m == 0 && c == 8) lose_req = 1'b0;
            end
            step();
            n_checks++;
            if ({enable_sound, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL win_lose m%0d idle: got en/busy/done %b want 000",
                         m, {enable_sound, busy, done});
            end
            if (m == 0) step();
        end
    endtask

    // gate_req held across the whole first GATE melody: exactly one replay.
    task automatic test_back_to_back;
        logic [2:0] got, want;
        logic       en_e;
        gate_req = 1'b1;
        step();
        for (int c = 1; c <= 14; c++) begin
            if (c > 1) step();
            en_e = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            got  = {enable_sound, busy, done};
            want = {en_e, (c <= 5) || (c >= 7 && c <= 11), (c == 5) || (c == 11)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back c%0d en/busy/done: got %b want %b", c, got, want);
            end
            if (en_e) begin
                n_checks++;
                if (sound_freq_out !== 10'd800) begin
                    n_fail++;
                    $display("FAIL back_to_back c%0d freq: got %0d want 800", c, sound_freq_out);
                end
            end
            if (c == 5) gate_req = 1'b0;
        end
    endtask

    // Reset mid-note clears outputs at once and drops the pending GATE.
    task automatic test_reset_mid_note;
        gate_req = 1'b1;
        step();
        step();
        gate_req = 1'b0;
        n_checks++;
        if (enable_sound !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid playing: got en=%b want 1", enable_sound);
        end
        #2 resetN = 1'b0;
        #1;
        n_checks++;
        if ({sound_freq_out, enable_sound, busy, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid async: got freq=%0d en=%b busy=%b done=%b want all 0",
                     sound_freq_out, enable_sound, busy, done);
        end
        step();
        resetN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if ({sound_freq_out, enable_sound, busy, done} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_mid idle k%0d: got freq=%0d en=%b busy=%b done=%b want all 0",
                         k, sound_freq_out, enable_sound, busy, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lose_single();
        test_lose_win_same_cycle();
        test_gate_preempt();
        test_win_then_lose();
        test_back_to_back();
        test_reset_mid_note();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
